// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: fetch PC, in-order imem requests, DEPTH-entry
// instruction FIFO toward decode. Optional macro: IFQ_MISALIGN_EN.
module instr_fetch_queue #(
    parameter int                  DEPTH       = 2,
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc
`ifdef IFQ_MISALIGN_EN
    ,
    output logic                   fetch_misalign
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1) + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [PC_WIDTH-1:0]    fpc;
    cnt_t                   inflight;
    cnt_t                   discard;
    cnt_t                   count;
    cnt_t                   occupancy;
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          tag_rd;
    logic [AW-1:0]          tag_wr;
    logic [PC_WIDTH-1:0]    fifo_pc    [DEPTH];
    logic [INSTR_WIDTH-1:0] fifo_instr [DEPTH];
    logic [PC_WIDTH-1:0]    tag_q      [DEPTH];
    logic [PC_WIDTH-1:0]    redirect_tgt;
    logic                   misalign;
    logic                   pop;
    logic                   accept;
    logic                   drop;
    logic                   push;

`ifdef IFQ_MISALIGN_EN
    assign redirect_tgt   = redirect_pc;
    assign fetch_misalign = misalign;

    // Sticky misalign flag, re-evaluated on every redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign <= 1'b0;
        end else if (redirect) begin
            misalign <= |redirect_pc[1:0];
        end
    end
`else
    assign redirect_tgt = redirect_pc & ~PC_WIDTH'(3);
    assign misalign     = 1'b0;
`endif

    // Credits count queued entries plus outstanding requests, net of this pop
    assign instr_valid    = (count != '0);
    assign pop            = instr_valid & instr_ready;
    assign occupancy      = count + inflight - cnt_t'(pop);
    assign imem_req_valid = rst & ~redirect & ~misalign
                          & (occupancy < DEPTH_C);
    assign imem_req_addr  = fpc;
    assign accept         = imem_req_valid & imem_req_ready;
    assign drop           = (discard != '0) | redirect;
    assign push           = imem_rsp_valid & ~drop;
    assign instr          = fifo_instr[rd_ptr];
    assign instr_pc       = fifo_pc[rd_ptr];

    // Fetch PC, flight/discard/occupancy counters and queue pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc      <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
        end else begin
            inflight <= inflight + cnt_t'(accept)
                      - cnt_t'(imem_rsp_valid);
            if (accept) begin
                tag_wr <= tag_wr + AW'(1);
            end
            if (imem_rsp_valid) begin
                tag_rd <= tag_rd + AW'(1);
            end
            if (redirect) begin
                fpc     <= redirect_tgt;
                discard <= inflight - cnt_t'(imem_rsp_valid);
                count   <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
            end else begin
                if (accept) begin
                    fpc <= fpc + PC_WIDTH'(4);
                end
                if (imem_rsp_valid && (discard != '0)) begin
                    discard <= discard - cnt_t'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    // Tag queue written on accept; FIFO written with {tag, data} on response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
                tag_q[i]      <= '0;
            end
        end else begin
            if (accept) begin
                tag_q[tag_wr] <= fpc;
            end
            if (push) begin
                fifo_pc[wr_ptr]    <= tag_q[tag_rd];
                fifo_instr[wr_ptr] <= imem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (DEPTH=2) with a latency-programmable
// in-order instruction memory; memory data = {16'hC0DE, addr[15:0]}.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef IFQ_MISALIGN_EN
    logic        fetch_misalign;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat   = 1;
    int n_acc = 0;

    logic [31:0] mq_addr [$];
    int          mq_due  [$];

    instr_fetch_queue #(
        .DEPTH(2),
        .PC_WIDTH(32),
        .INSTR_WIDTH(32),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc)
`ifdef IFQ_MISALIGN_EN
        ,
        .fetch_misalign(fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    // Memory: record accepted requests mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            n_acc = 0;
        end else if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
            n_acc++;
        end
    end

    // Memory: drive the in-order response due in the new cycle
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst) begin
            mq_addr.delete();
            mq_due.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else if (mq_due.size() != 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = {16'hC0DE, mq_addr[0][15:0]};
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic start(input int l, input logic rr, input logic ir);
        nx();
        rst            = 1'b0;
        redirect       = 1'b0;
        lat            = l;
        imem_req_ready = rr;
        instr_ready    = ir;
        nx();
        nx();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        // Reset values
        mid();
        mid();
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_instr_pc", 64'(instr_pc), 64'd0);
`ifdef IFQ_MISALIGN_EN
        chk("rst_misalign", 64'(fetch_misalign), 64'd0);
`endif

        // Streaming with 1-cycle memory
        start(1, 1'b1, 1'b1);
        mid();
        chk("t1_c0_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t1_c0_addr", 64'(imem_req_addr), 64'h0);
        chk("t1_c0_iv", 64'(instr_valid), 64'd0);
        nx(); mid();
        chk("t1_c1_iv", 64'(instr_valid), 64'd0);
        chk("t1_c1_addr", 64'(imem_req_addr), 64'h4);
        nx(); mid();
        chk("t1_c2_iv", 64'(instr_valid), 64'd1);
        chk("t1_c2_pc", 64'(instr_pc), 64'h0);
        chk("t1_c2_instr", 64'(instr), 64'hC0DE_0000);
        nx(); mid();
        chk("t1_c3_pc", 64'(instr_pc), 64'h4);
        nx(); mid();
        chk("t1_c4_pc", 64'(instr_pc), 64'h8);
        nx(); mid();
        chk("t1_c5_pc", 64'(instr_pc), 64'hC);
        chk("t1_c5_instr", 64'(instr), 64'hC0DE_000C);

        // Decode stalled: queue fills at two entries
        start(1, 1'b1, 1'b0);
        mid();
        chk("t2_c0_addr", 64'(imem_req_addr), 64'h0);
        nx(); mid();
        chk("t2_c1_valid", 64'(imem_req_valid), 64'd1);
        chk("t2_c1_addr", 64'(imem_req_addr), 64'h4);
        nx(); mid();
        chk("t2_c2_valid", 64'(imem_req_valid), 64'd0);
        chk("t2_c2_pc", 64'(instr_pc), 64'h0);
        nx(); mid();
        chk("t2_c3_valid", 64'(imem_req_valid), 64'd0);
        chk("t2_c3_instr", 64'(instr), 64'hC0DE_0000);
        nx(); mid();
        chk("t2_c4_nacc", 64'(n_acc), 64'd2);
        chk("t2_c4_valid", 64'(imem_req_valid), 64'd0);
        nx();
        instr_ready = 1'b1;
        mid();
        chk("t2_c5_pc", 64'(instr_pc), 64'h0);
        chk("t2_c5_valid", 64'(imem_req_valid), 64'd1);
        chk("t2_c5_addr", 64'(imem_req_addr), 64'h8);
        nx(); mid();
        chk("t2_c6_pc", 64'(instr_pc), 64'h4);
        nx(); mid();
        chk("t2_c7_pc", 64'(instr_pc), 64'h8);

        // Memory back-pressure holds the request
        start(1, 1'b0, 1'b1);
        mid();
        chk("t3_c0_valid", 64'(imem_req_valid), 64'd1);
        chk("t3_c0_addr", 64'(imem_req_addr), 64'h0);
        nx(); mid();
        chk("t3_c1_addr", 64'(imem_req_addr), 64'h0);
        nx(); mid();
        chk("t3_c2_valid", 64'(imem_req_valid), 64'd1);
        chk("t3_c2_addr", 64'(imem_req_addr), 64'h0);
        nx();
        imem_req_ready = 1'b1;
        mid();
        chk("t3_c3_addr", 64'(imem_req_addr), 64'h0);
        nx(); mid();
        chk("t3_c4_addr", 64'(imem_req_addr), 64'h4);
        nx(); mid();
        chk("t3_c5_iv", 64'(instr_valid), 64'd1);
        chk("t3_c5_pc", 64'(instr_pc), 64'h0);

        // 3-cycle memory, redirect with 0x8/0xC in flight
        start(3, 1'b1, 1'b1);
        mid();
        nx(); mid();
        nx(); mid();
        chk("t4_c2_valid", 64'(imem_req_valid), 64'd0);
        nx(); mid();
        nx(); mid();
        chk("t4_c4_pc", 64'(instr_pc), 64'h0);
        chk("t4_c4_addr", 64'(imem_req_addr), 64'h8);
        nx(); mid();
        chk("t4_c5_pc", 64'(instr_pc), 64'h4);
        chk("t4_c5_addr", 64'(imem_req_addr), 64'hC);
        nx();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        mid();
        chk("t4_c6_valid", 64'(imem_req_valid), 64'd0);
        nx();
        redirect = 1'b0;
        mid();
        chk("t4_c7_iv", 64'(instr_valid), 64'd0);
        chk("t4_c7_valid", 64'(imem_req_valid), 64'd0);
        nx(); mid();
        chk("t4_c8_iv", 64'(instr_valid), 64'd0);
        chk("t4_c8_valid", 64'(imem_req_valid), 64'd1);
        chk("t4_c8_addr", 64'(imem_req_addr), 64'h100);
        nx(); mid();
        chk("t4_c9_iv", 64'(instr_valid), 64'd0);
        chk("t4_c9_addr", 64'(imem_req_addr), 64'h104);
        nx(); mid();
        chk("t4_c10_iv", 64'(instr_valid), 64'd0);
        nx(); mid();
        chk("t4_c11_iv", 64'(instr_valid), 64'd0);
        nx(); mid();
        chk("t4_c12_iv", 64'(instr_valid), 64'd1);
        chk("t4_c12_pc", 64'(instr_pc), 64'h100);
        chk("t4_c12_instr", 64'(instr), 64'hC0DE_0100);
        nx(); mid();
        chk("t4_c13_pc", 64'(instr_pc), 64'h104);

        // Redirect coinciding with a response and a pop
        start(1, 1'b1, 1'b1);
        mid();
        nx(); mid();
        nx();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        mid();
        chk("t5_c2_iv", 64'(instr_valid), 64'd1);
        chk("t5_c2_pc", 64'(instr_pc), 64'h0);
        chk("t5_c2_rsp", 64'(imem_rsp_valid), 64'd1);
        chk("t5_c2_valid", 64'(imem_req_valid), 64'd0);
        nx();
        redirect = 1'b0;
        mid();
        chk("t5_c3_iv", 64'(instr_valid), 64'd0);
        chk("t5_c3_valid", 64'(imem_req_valid), 64'd1);
        chk("t5_c3_addr", 64'(imem_req_addr), 64'h100);
        nx(); mid();
        chk("t5_c4_iv", 64'(instr_valid), 64'd0);
        nx(); mid();
        chk("t5_c5_pc", 64'(instr_pc), 64'h100);
        chk("t5_c5_instr", 64'(instr), 64'hC0DE_0100);
        nx();
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        mid();
        chk("t5_c6_pc", 64'(instr_pc), 64'h104);
        nx();
        redirect = 1'b0;
        mid();
`ifdef IFQ_MISALIGN_EN
        chk("t5_c7_misalign", 64'(fetch_misalign), 64'd1);
        chk("t5_c7_valid", 64'(imem_req_valid), 64'd0);
        nx(); mid();
        chk("t5_c8_valid", 64'(imem_req_valid), 64'd0);
        nx();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        mid();
        chk("t5_c9_misalign", 64'(fetch_misalign), 64'd1);
        nx();
        redirect = 1'b0;
        mid();
        chk("t5_c10_misalign", 64'(fetch_misalign), 64'd0);
        chk("t5_c10_valid", 64'(imem_req_valid), 64'd1);
        chk("t5_c10_addr", 64'(imem_req_addr), 64'h200);
`else
        chk("t5_c7_valid", 64'(imem_req_valid), 64'd1);
        chk("t5_c7_addr", 64'(imem_req_addr), 64'h100);
        nx(); mid();
        chk("t5_c8_addr", 64'(imem_req_addr), 64'h104);
`endif

        // Asynchronous reset with a full queue
        start(1, 1'b1, 1'b0);
        mid();
        nx(); mid();
        nx(); mid();
        nx(); mid();
        chk("t6_full_iv", 64'(instr_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_iv", 64'(instr_valid), 64'd0);
        chk("t6_async_valid", 64'(imem_req_valid), 64'd0);
        chk("t6_async_instr", 64'(instr), 64'd0);
        chk("t6_async_pc", 64'(instr_pc), 64'd0);
        nx();
        nx();
        rst = 1'b1;
        mid();
        chk("t6_c0_valid", 64'(imem_req_valid), 64'd1);
        chk("t6_c0_addr", 64'(imem_req_addr), 64'h0);
        chk("t6_c0_iv", 64'(instr_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
